// File: rtl/rr_byte_arbiter.sv
// Four-channel round-robin byte arbiter.
// A winner is chosen in IDLE (or straight out of a HOLD handshake), and its
// byte is captured one cycle later in SETTLE, together with a one-cycle grant
// pulse. The byte then sits in HOLD until downstream accepts it.
module rr_byte_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din3,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din0,
    input  logic             out_ready,
    output logic             sel1,
    output logic             sel0,
    output logic [3:0]       gnt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [7:0]       xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [7:0]       xfer_cnt_q, xfer_cnt_d;

    logic [3:0]       elig;
    logic [1:0]       winner;
    logic [WIDTH-1:0] din_sel;

    // Round-robin search starting just after the last served channel.
    // Offset 4 wraps back onto ptr itself, so it has the lowest priority.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr,
                                           input logic [3:0] mask);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = ptr;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && mask[idx]) begin
                res   = idx;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    // A channel holding the grant pulse this cycle is not eligible, so a
    // source that drops req one cycle after gnt is never served twice.
    always_comb begin
        elig   = req & ~gnt_q;
        winner = rr_pick(ptr_q, elig);
    end

    // Data mux driven by the registered select.
    always_comb begin
        din_sel = din0;
        case (sel_q)
            2'd0:    din_sel = din0;
            2'd1:    din_sel = din1;
            2'd2:    din_sel = din2;
            default: din_sel = din3;
        endcase
    end

    // Next-state and datapath updates; gnt defaults low so it only pulses.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        gnt_d       = 4'b0000;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        xfer_cnt_d  = xfer_cnt_q;
        case (state_q)
            IDLE: begin
                if (|elig) begin
                    sel_d   = winner;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                out_data_d  = din_sel;
                out_valid_d = 1'b1;
                gnt_d       = 4'b0001 << sel_q;
                ptr_d       = sel_q;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    xfer_cnt_d  = xfer_cnt_q + 8'd1;
                    out_valid_d = 1'b0;
                    if (|elig) begin
                        sel_d   = winner;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transfer in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            ptr_q       <= 2'd3;
            gnt_q       <= 4'b0000;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            xfer_cnt_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign sel1      = sel_q[1];
    assign sel0      = sel_q[0];
    assign gnt       = gnt_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_byte_arbiter.sv
// Bench for rr_byte_arbiter: a vector table, directed multi-cycle sequences
// and a randomized run compared against a transaction-level model.
module tb_rr_byte_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] d0, d1, d2, d3;
    logic       out_ready;
    logic       sel1, sel0;
    logic [3:0] gnt;
    logic       out_valid;
    logic [7:0] out_data;
    logic [7:0] xfer_cnt;

    int n_total = 0;
    int n_pass  = 0;

    rr_byte_arbiter #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req),
        .din3(d3), .din2(d2), .din1(d1), .din0(d0),
        .out_ready(out_ready),
        .sel1(sel1), .sel0(sel0), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic       ov;
        logic [7:0] od;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // ---- reference model: channel indices as ints, -1 means no grant ----
    int m_phase, m_sel, m_gnt, m_ov, m_od, m_cnt, m_ptr;

    task automatic model_reset();
        m_phase = 0; m_sel = 0; m_gnt = -1; m_ov = 0; m_od = 0; m_cnt = 0; m_ptr = 3;
    endtask

    task automatic model_edge();
        bit el[4];
        bit any;
        int win;
        int nxt_gnt;
        logic [7:0] din_a[4];
        din_a[0] = d0; din_a[1] = d1; din_a[2] = d2; din_a[3] = d3;
        any = 0;
        for (int n = 0; n < 4; n++) begin
            el[n] = req[n] && (m_gnt != n);
            if (el[n]) any = 1;
        end
        win = -1;
        for (int k = 1; k <= 4; k++)
            if (win < 0 && el[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
        if (!rst_n) begin
            model_reset();
        end else begin
            nxt_gnt = -1;
            if (m_phase == 0) begin
                if (any) begin m_sel = win; m_phase = 1; end
            end else if (m_phase == 1) begin
                m_od = din_a[m_sel]; m_ov = 1; nxt_gnt = m_sel; m_ptr = m_sel; m_phase = 2;
            end else if (out_ready) begin
                m_cnt = (m_cnt + 1) % 256;
                m_ov = 0;
                if (any) begin m_sel = win; m_phase = 1; end
                else m_phase = 0;
            end
            m_gnt = nxt_gnt;
        end
    endtask

    initial begin
        logic [31:0] exp_gnt;
        int  hs;
        bit  pend;
        bit  seen255;

        rst_n = 1'b0; req = 4'h0; out_ready = 1'b1;
        d0 = 8'd7; d1 = 8'd6; d2 = 8'd5; d3 = 8'd2;

        //        rst   req   rdy   sel  gnt   ov   od     cnt
        tbl[0]  = {1'b0, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[1]  = {1'b1, 4'h1, 1'b1, 2'd0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[2]  = {1'b1, 4'h1, 1'b1, 2'd0, 4'h1, 1'b1, 8'd7, 8'd0};
        tbl[3]  = {1'b1, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 8'd7, 8'd1};
        tbl[4]  = {1'b0, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[5]  = {1'b1, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 8'd0, 8'd0};
        tbl[6]  = {1'b1, 4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 8'd7, 8'd0};
        tbl[7]  = {1'b1, 4'hF, 1'b1, 2'd1, 4'h0, 1'b0, 8'd7, 8'd1};
        tbl[8]  = {1'b1, 4'hF, 1'b1, 2'd1, 4'h2, 1'b1, 8'd6, 8'd1};
        tbl[9]  = {1'b1, 4'hF, 1'b1, 2'd2, 4'h0, 1'b0, 8'd6, 8'd2};
        tbl[10] = {1'b1, 4'hF, 1'b1, 2'd2, 4'h4, 1'b1, 8'd5, 8'd2};
        tbl[11] = {1'b1, 4'hF, 1'b1, 2'd3, 4'h0, 1'b0, 8'd5, 8'd3};
        tbl[12] = {1'b1, 4'hF, 1'b1, 2'd3, 4'h8, 1'b1, 8'd2, 8'd3};
        tbl[13] = {1'b1, 4'hF, 1'b1, 2'd0, 4'h0, 1'b0, 8'd2, 8'd4};
        tbl[14] = {1'b1, 4'hF, 1'b1, 2'd0, 4'h1, 1'b1, 8'd7, 8'd4};
        tbl[15] = {1'b1, 4'h0, 1'b1, 2'd0, 4'h0, 1'b0, 8'd7, 8'd5};
        tbl[16] = {1'b1, 4'h8, 1'b1, 2'd3, 4'h0, 1'b0, 8'd7, 8'd5};
        tbl[17] = {1'b1, 4'hA, 1'b1, 2'd3, 4'h8, 1'b1, 8'd2, 8'd5};
        tbl[18] = {1'b1, 4'hA, 1'b1, 2'd1, 4'h0, 1'b0, 8'd2, 8'd6};
        tbl[19] = {1'b1, 4'hA, 1'b1, 2'd1, 4'h2, 1'b1, 8'd6, 8'd6};
        tbl[20] = {1'b1, 4'hA, 1'b1, 2'd3, 4'h0, 1'b0, 8'd6, 8'd7};
        tbl[21] = {1'b1, 4'hA, 1'b1, 2'd3, 4'h8, 1'b1, 8'd2, 8'd7};
        tbl[22] = {1'b1, 4'h0, 1'b1, 2'd3, 4'h0, 1'b0, 8'd2, 8'd8};
        tbl[23] = {1'b1, 4'h0, 1'b1, 2'd3, 4'h0, 1'b0, 8'd2, 8'd8};

        for (int i = 0; i < 24; i++) begin
            rst_n = tbl[i].rst_n; req = tbl[i].req; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("tbl%0d_sel", i), {sel1, sel0}, tbl[i].sel);
            chk($sformatf("tbl%0d_gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
            chk($sformatf("tbl%0d_od", i), out_data, tbl[i].od);
            chk($sformatf("tbl%0d_cnt", i), xfer_cnt, tbl[i].cnt);
        end

        // Backpressure: byte and select held while downstream stalls.
        do_reset();
        req = 4'b0100; out_ready = 1'b0;
        step();
        chk("bp_sel_settle", {sel1, sel0}, 2'd2);
        chk("bp_ov_settle", out_valid, 1'b0);
        step();
        chk("bp_gnt", gnt, 4'b0100);
        chk("bp_od", out_data, 8'd5);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_hold_ov", out_valid, 1'b1);
            chk("bp_hold_od", out_data, 8'd5);
            chk("bp_hold_sel", {sel1, sel0}, 2'd2);
            chk("bp_hold_cnt", xfer_cnt, 8'd0);
            chk("bp_hold_gnt", gnt, 4'b0000);
        end
        out_ready = 1'b1; req = 4'b0000;
        step();
        chk("bp_release_ov", out_valid, 1'b0);
        chk("bp_release_cnt", xfer_cnt, 8'd1);

        // Reset in HOLD discards the byte and the count.
        req = 4'b0100; out_ready = 1'b0;
        step();
        step();
        chk("rh_od_before", out_data, 8'd5);
        chk("rh_ov_before", out_valid, 1'b1);
        rst_n = 1'b0;
        step();
        chk("rh_ov", out_valid, 1'b0);
        chk("rh_od", out_data, 8'd0);
        chk("rh_sel", {sel1, sel0}, 2'd0);
        chk("rh_cnt", xfer_cnt, 8'd0);
        chk("rh_gnt", gnt, 4'b0000);
        rst_n = 1'b1; req = 4'b0000; out_ready = 1'b1;
        step();
        chk("rh_after_ov", out_valid, 1'b0);
        chk("rh_after_gnt", gnt, 4'b0000);

        // Reset in SETTLE suppresses the grant pulse.
        req = 4'b0010;
        step();
        chk("rs_sel", {sel1, sel0}, 2'd1);
        rst_n = 1'b0;
        step();
        chk("rs_gnt", gnt, 4'b0000);
        chk("rs_ov", out_valid, 1'b0);
        rst_n = 1'b1; req = 4'b0000;
        step();
        chk("rs_after_gnt", gnt, 4'b0000);

        // Counter wrap after 256 accepted transfers.
        do_reset();
        req = 4'b0001; out_ready = 1'b1;
        hs = 0; seen255 = 0;
        for (int cyc = 0; cyc < 1500 && hs < 256; cyc++) begin
            pend = out_valid && out_ready;
            step();
            if (pend) hs++;
            if (hs == 255 && !seen255) begin
                seen255 = 1;
                chk("wrap_cnt255", xfer_cnt, 8'd255);
            end
        end
        chk("wrap_handshakes", hs, 256);
        chk("wrap_cnt0", xfer_cnt, 8'd0);
        req = 4'b0000;

        // Randomized traffic against the model.
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n     = (i == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            req       = 4'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 8'($urandom);
            model_edge();
            step();
            exp_gnt = (m_gnt < 0) ? 32'd0 : (32'd1 << m_gnt);
            chk("rnd_sel", {sel1, sel0}, m_sel);
            chk("rnd_gnt", gnt, exp_gnt);
            chk("rnd_ov", out_valid, m_ov);
            chk("rnd_od", out_data, m_od);
            chk("rnd_cnt", xfer_cnt, m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
